// File: rtl/op2_imm_encoder_if.sv
// Request/response bundle for op2_imm_encoder: a 32-bit constant in, an operand-2 encoding out.
// Both directions use valid/ready; the encoder side is the slave modport.
`timescale 1ns/1ps
interface op2_imm_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic        out_valid;
   logic        out_ready;
   logic        out_found;
   logic        out_invert;
   logic [12:0] out_op2;

   modport master (
      output in_valid, in_value, out_ready,
      input  in_ready, out_valid, out_found, out_invert, out_op2
   );

   modport slave (
      input  in_valid, in_value, out_ready,
      output in_ready, out_valid, out_found, out_invert, out_op2
   );
endinterface

// File: rtl/op2_imm_encoder.sv
// Finds the lowest even rotation expressing a 32-bit constant as ROR(imm8, 2*rot); OP2_IMM_INVERT_EN also accepts ~value.
// Latency k+1 edges for a hit at rot k, else 16; result held until out_ready, input accepted only when idle.
`timescale 1ns/1ps
module op2_imm_encoder (
   input  logic              clk,
   input  logic              rst_n,
   op2_imm_encoder_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  rot_q, rot_d;
   logic [31:0] val_q, val_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic        out_found_q, out_found_d;
   logic        out_invert_q, out_invert_d;
   logic [12:0] out_op2_q, out_op2_d;

   logic [4:0]  shamt;
   logic [31:0] rol_val;
   logic        plain_hit;

`ifdef OP2_IMM_INVERT_EN
   logic        inv_found_q, inv_found_d;
   logic [11:0] inv_field_q, inv_field_d;
   logic        inv_hit;
   logic [11:0] inv_field_now;
`endif

   // ROL(v, s) as two shifts; a right shift by 32 yields zero, which covers s == 0.
   always_comb begin
      shamt     = {rot_q, 1'b0};
      rol_val   = (val_q << shamt) | (val_q >> (6'd32 - {1'b0, shamt}));
      plain_hit = (rol_val[31:8] == 24'h0);
   end

`ifdef OP2_IMM_INVERT_EN
   // ROL(~v) == ~ROL(v), so the inverted test reuses the same rotator.
   always_comb begin
      inv_hit       = &rol_val[31:8];
      inv_field_now = {rot_q, ~rol_val[7:0]};
   end
`endif

   always_comb begin
      state_d      = state_q;
      rot_d        = rot_q;
      val_d        = val_q;
      in_ready_d   = in_ready_q;
      out_valid_d  = out_valid_q;
      out_found_d  = out_found_q;
      out_invert_d = out_invert_q;
      out_op2_d    = out_op2_q;
`ifdef OP2_IMM_INVERT_EN
      inv_found_d  = inv_found_q;
      inv_field_d  = inv_field_q;
`endif

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               val_d      = bus.in_value;
               rot_d      = 4'd0;
               in_ready_d = 1'b0;
               state_d    = SEARCH;
`ifdef OP2_IMM_INVERT_EN
               inv_found_d = 1'b0;
               inv_field_d = 12'h0;
`endif
            end
         end

         SEARCH: begin
`ifdef OP2_IMM_INVERT_EN
            if (!inv_found_q && inv_hit) begin
               inv_found_d = 1'b1;
               inv_field_d = inv_field_now;
            end
`endif
            if (plain_hit) begin
               out_valid_d  = 1'b1;
               out_found_d  = 1'b1;
               out_invert_d = 1'b0;
               out_op2_d    = {1'b1, rot_q, rol_val[7:0]};
               state_d      = DONE;
            end else if (rot_q == 4'hF) begin
               out_valid_d  = 1'b1;
               out_found_d  = 1'b0;
               out_invert_d = 1'b0;
               out_op2_d    = 13'h0;
               state_d      = DONE;
`ifdef OP2_IMM_INVERT_EN
               // The last rotation may itself be the first inverted hit.
               if (inv_found_q) begin
                  out_found_d  = 1'b1;
                  out_invert_d = 1'b1;
                  out_op2_d    = {1'b1, inv_field_q};
               end else if (inv_hit) begin
                  out_found_d  = 1'b1;
                  out_invert_d = 1'b1;
                  out_op2_d    = {1'b1, inv_field_now};
               end
`endif
            end else begin
               rot_d = rot_q + 4'd1;
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rot_q        <= 4'd0;
         val_q        <= 32'h0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_found_q  <= 1'b0;
         out_invert_q <= 1'b0;
         out_op2_q    <= 13'h0;
`ifdef OP2_IMM_INVERT_EN
         inv_found_q  <= 1'b0;
         inv_field_q  <= 12'h0;
`endif
      end else begin
         state_q      <= state_d;
         rot_q        <= rot_d;
         val_q        <= val_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_found_q  <= out_found_d;
         out_invert_q <= out_invert_d;
         out_op2_q    <= out_op2_d;
`ifdef OP2_IMM_INVERT_EN
         inv_found_q  <= inv_found_d;
         inv_field_q  <= inv_field_d;
`endif
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_found  = out_found_q;
   assign bus.out_invert = out_invert_q;
   assign bus.out_op2    = out_op2_q;

endmodule

// File: tb/tb_op2_imm_encoder.sv
// Bench for op2_imm_encoder: brute-force reference over all (imm8, rot) pairs, checked every cycle, plus literal vectors.
`timescale 1ns/1ps
module tb_op2_imm_encoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   op2_imm_encoder_if bus_if ();

   op2_imm_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
      logic [63:0] t;
      t = {x, x} >> s;
      return t[31:0];
   endfunction

   // Reference: the first (rot, imm8) pair in rot order whose ROR reproduces the value.
   function automatic void ref_enc(input logic [31:0] v, output logic f, output logic inv,
                                   output logic [12:0] op2, output int lat);
      f = 1'b0; inv = 1'b0; op2 = 13'h0; lat = 16;
      for (int r = 0; r < 16; r++)
         for (int i = 0; i < 256; i++)
            if (ror32(32'(i), 2 * r) == v) begin
               f = 1'b1; op2 = {1'b1, 4'(r), 8'(i)}; lat = r + 1;
               return;
            end
`ifdef OP2_IMM_INVERT_EN
      for (int r = 0; r < 16; r++)
         for (int i = 0; i < 256; i++)
            if (ror32(32'(i), 2 * r) == ~v) begin
               f = 1'b1; inv = 1'b1; op2 = {1'b1, 4'(r), 8'(i)};
               return;
            end
`endif
   endfunction

   // Model phases: 0 waiting for input, 1 searching, 2 result presented.
   int          m_phase = 0;
   int          m_cnt = 0;
   int          m_lat = 0;
   logic        m_f = 1'b0;
   logic        m_i = 1'b0;
   logic [12:0] m_op2 = 13'h0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
      end else begin
         case (m_phase)
            0: if (bus_if.in_valid) begin
                  ref_enc(bus_if.in_value, m_f, m_i, m_op2, m_lat);
                  m_cnt = 0;
                  m_phase = 1;
               end
            1: begin
                  m_cnt++;
                  if (m_cnt == m_lat) m_phase = 2;
               end
            default: if (bus_if.out_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
         check("rst_out_found", 32'(bus_if.out_found), 32'd0);
         check("rst_out_invert", 32'(bus_if.out_invert), 32'd0);
         check("rst_out_op2", 32'(bus_if.out_op2), 32'd0);
      end else begin
         check("model_in_ready", 32'(bus_if.in_ready), 32'(m_phase == 0));
         check("model_out_valid", 32'(bus_if.out_valid), 32'(m_phase == 2));
         if (m_phase == 2) begin
            check("model_found", 32'(bus_if.out_found), 32'(m_f));
            check("model_invert", 32'(bus_if.out_invert), 32'(m_i));
            check("model_op2", 32'(bus_if.out_op2), 32'(m_op2));
         end
      end
   end

   task automatic accept(input logic [31:0] v);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus_if.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_in_ready", 32'(bus_if.in_ready), 32'd1);
      bus_if.in_valid = 1'b1;
      bus_if.in_value = v;
      @(posedge clk);
      #1 bus_if.in_valid = 1'b0;
   endtask

   task automatic run_vec(input string name, input logic [31:0] v, input int exp_lat,
                          input logic ef, input logic ei, input logic [12:0] eop, input int hold);
      int lat;
      accept(v);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus_if.out_valid) break;
      end
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_found"}, 32'(bus_if.out_found), 32'(ef));
      check({name, "_invert"}, 32'(bus_if.out_invert), 32'(ei));
      check({name, "_op2"}, 32'(bus_if.out_op2), 32'(eop));
      repeat (hold) begin
         @(negedge clk);
         check({name, "_hold_valid"}, 32'(bus_if.out_valid), 32'd1);
         check({name, "_hold_op2"}, 32'(bus_if.out_op2), 32'(eop));
         check({name, "_hold_found"}, 32'(bus_if.out_found), 32'(ef));
      end
      @(negedge clk);
      bus_if.out_ready = 1'b1;
      bus_if.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus_if.out_ready = 1'b0;
      bus_if.in_valid  = 1'b0;
      check({name, "_consumed_valid"}, 32'(bus_if.out_valid), 32'd0);
      check({name, "_idle_ready"}, 32'(bus_if.in_ready), 32'd1);
   endtask

   function automatic logic [31:0] gen_val();
      logic [31:0] base;
      base = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
      case ($urandom_range(0, 4))
         0:       return base;
         1:       return ~base;
         2:       return $urandom;
         3:       return ror32(32'($urandom_range(0, 255)), int'($urandom_range(0, 31)));
         default: return 32'($urandom_range(0, 255)) << $urandom_range(0, 24);
      endcase
   endfunction

   initial begin
      bus_if.in_valid  = 1'b0;
      bus_if.in_value  = 32'h0;
      bus_if.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1 check("post_reset_in_ready", 32'(bus_if.in_ready), 32'd1);

      run_vec("zero", 32'h00000000, 1, 1'b1, 1'b0, 13'h1000, 0);
      run_vec("ff000000", 32'hFF000000, 5, 1'b1, 1'b0, 13'h14FF, 0);
      run_vec("3fc", 32'h000003FC, 16, 1'b1, 1'b0, 13'h1FFF, 10);
`ifdef OP2_IMM_INVERT_EN
      run_vec("ffffff00", 32'hFFFFFF00, 16, 1'b1, 1'b1, 13'h10FF, 2);
`else
      run_vec("ffffff00", 32'hFFFFFF00, 16, 1'b0, 1'b0, 13'h0000, 2);
`endif
      run_vec("101", 32'h00000101, 16, 1'b0, 1'b0, 13'h0000, 0);
      run_vec("c0000003", 32'hC0000003, 2, 1'b1, 1'b0, 13'h110F, 0);

      accept(32'h000003FC);
      repeat (6) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midsearch_rst_valid", 32'(bus_if.out_valid), 32'd0);
      check("midsearch_rst_op2", 32'(bus_if.out_op2), 32'd0);
      check("midsearch_rst_found", 32'(bus_if.out_found), 32'd0);
      check("midsearch_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("after_rst_no_valid", 32'(bus_if.out_valid), 32'd0);
         check("after_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
      end
      run_vec("zero_after_rst", 32'h00000000, 1, 1'b1, 1'b0, 13'h1000, 0);

      repeat (3000) begin
         @(negedge clk);
         bus_if.in_valid  = ($urandom_range(0, 3) != 0);
         bus_if.in_value  = gen_val();
         bus_if.out_ready = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      repeat (40) @(negedge clk);
      check("drain_in_ready", 32'(bus_if.in_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/op2_imm_encoder.md
OP2_IMM_ENCODER -- requirements
Module: op2_imm_encoder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  in_value presented for encoding.
REQ-005 Port: in_ready  output  1  block idle and able to accept in_value.
REQ-006 Port: in_value  input  32  constant to encode as a data-processing immediate operand 2.
REQ-007 Port: out_valid  output  1  result fields valid and held.
REQ-008 Port: out_ready  input  1  consumer accepts the result.
REQ-009 Port: out_found  output  1  an encoding was found.
REQ-010 Port: out_invert  output  1  the encoding represents the bitwise NOT of in_value (MOV<->MVN, AND<->BIC substitution).
REQ-011 Port: out_op2  output  13  operand-2 field {1'b1 immediate flag, rot[3:0], imm8[7:0]}, meaning value = ROR(imm8, 2*rot).

Function
REQ-012 States: IDLE, SEARCH, DONE. in_ready SHALL be 1 only in IDLE.
REQ-013 In IDLE, in_valid=1 SHALL capture in_value into an internal register, clear the candidate counter rot to 0, and move to SEARCH at the same edge.
REQ-014 In SEARCH, each cycle SHALL test one rot: hit when ROL(captured value, 2*rot)[31:8] == 0, with imm8 = ROL(captured value, 2*rot)[7:0].
REQ-015 On a plain hit, the block SHALL register out_found=1, out_invert=0, out_op2={1,rot,imm8}, and enter DONE at that edge. The lowest hitting rot wins.
REQ-016 With no plain hit at rot=15, the block SHALL enter DONE with the fallback result (REQ-025/REQ-026). rot SHALL never wrap back to 0 within one search.
REQ-017 Latency: out_valid SHALL rise k+1 clock edges after the accepting edge for a plain hit at rot k, and 16 edges after it when there is no plain hit.
REQ-018 In DONE, out_valid=1 and all result outputs SHALL hold stable until out_ready=1. At that edge the block SHALL return to IDLE with out_valid=0.
REQ-019 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-020 A new input SHALL NOT be accepted in the same cycle a result is consumed. in_ready rises the cycle after the DONE->IDLE transition.
REQ-021 When no encoding is found, out_found=0, out_invert=0 and out_op2=13'h0.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, rot=0, the captured value to 0, and out_valid, out_found, out_invert and out_op2 to 0.
REQ-023 After reset, in_ready SHALL be 1.
REQ-024 A reset during SEARCH or DONE SHALL discard the operation with no result emitted. Operation resumes at the first rising edge with rst_n high.

Configuration
REQ-025 Macro OP2_IMM_INVERT_EN defined: each SEARCH cycle SHALL also test ~value at the same rot. The first inverted hit (lowest rot) SHALL be remembered. If rot=15 completes with no plain hit, the result SHALL be out_found=1, out_invert=1, out_op2={1,rot_inv,imm8_inv}. A plain hit always takes priority and still exits early.
REQ-026 Macro OP2_IMM_INVERT_EN undefined: no inverted test logic, out_invert tied 0, and no plain hit after rot=15 yields the REQ-021 not-found result.

Verification
REQ-027 in_value=32'h00000000 -> out_valid 1 edge after accept, found=1, invert=0, op2=13'h1000.
REQ-028 in_value=32'hFF000000 -> out_valid 5 edges after accept, found=1, op2={1,4'h4,8'hFF}=13'h14FF.
REQ-029 in_value=32'h000003FC -> out_valid 16 edges after accept, found=1, op2={1,4'hF,8'hFF}=13'h1FFF. Holding out_ready=0 for 10 cycles keeps outputs stable.
REQ-030 in_value=32'hFFFFFF00 -> with OP2_IMM_INVERT_EN: 16 edges, found=1, invert=1, op2=13'h10FF. Without the macro: found=0, op2=0.
REQ-031 in_value=32'h00000101 -> 16 edges, found=0, invert=0, op2=0 in both configurations.
REQ-032 rst_n pulsed low during SEARCH of 32'h000003FC -> outputs 0 immediately, no out_valid. in_ready=1 after release, and a following 32'h0 encodes per REQ-027.
